// File: rtl/vblank_arbiter.sv
// vblank_arbiter: grants exclusive access to the shared board/sprite memory
// to one of two requesters during vertical blanking. Each requester gets at
// most one grant per blanking interval, ordered round-robin across frames.
// A grant ends on the holder's done pulse, on timeout, or when blanking ends.
//
// Optional feature: define FRAME_COUNTER_EN to build a 16-bit count of
// blanking intervals on frame_cnt; otherwise frame_cnt is tied to zero.
//
// Handshake: grant[i] high means requester i owns the memory this cycle.
// done[i] is a one-cycle pulse, honoured only while grant[i] is high.
// req is level-sensitive and only matters while arbitrating.
// Dropping req during a grant does not end that grant.
//
// fsm_state exposes the arbiter state for debug:
// 0 = ACTIVE, 1 = ARB, 2 = GRANT.

module vblank_arbiter #(
    parameter int TIMEOUT = 2048,
    parameter int TW      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic [1:0]  req,
    input  logic [1:0]  done,
    output logic [1:0]  grant,
    output logic        frame_tick,
    output logic        abort,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [1:0]  fsm_state
);

    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_ARB    = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          vblnk_d;
    logic          rise;
    logic          fall;

    logic [1:0]    served;
    logic [1:0]    served_next;
    logic          rr_ptr;
    logic          rr_next;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_next;
    logic [1:0]    grant_next;
    logic          abort_next;

    logic [1:0]    eligible;
    logic          sel_valid;
    logic          sel_idx;
    logic          g_idx;
    logic          done_hit;
    logic          timeout_hit;

    assign rise        = vblnk & ~vblnk_d;
    assign fall        = ~vblnk & vblnk_d;
    assign eligible    = req & ~served;
    assign g_idx       = grant[1];
    assign done_hit    = |(done & grant);
    assign timeout_hit = (tcnt == TLAST);
    assign fsm_state   = state;

    // Pick an eligible requester, preferring the round-robin pointer.
    always_comb begin
        sel_valid = |eligible;
        sel_idx   = rr_ptr;
        if (!eligible[rr_ptr]) begin
            sel_idx = ~rr_ptr;
        end
    end

    // State register; reset parks the arbiter until a fresh blanking rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACTIVE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. done beats fall, and fall beats timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACTIVE: begin
                if (rise) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!vblnk)         state_next = ST_ACTIVE;
                else if (sel_valid) state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (done_hit)         state_next = fall ? ST_ACTIVE : ST_ARB;
                else if (fall)        state_next = ST_ACTIVE;
                else if (timeout_hit) state_next = ST_ARB;
            end
            default: state_next = ST_ACTIVE;
        endcase
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        grant_next  = grant;
        abort_next  = 1'b0;
        served_next = served;
        rr_next     = rr_ptr;
        tcnt_next   = tcnt;
        case (state)
            ST_ACTIVE: begin
                grant_next = 2'b00;
                if (rise) served_next = 2'b00;
            end
            ST_ARB: begin
                grant_next = 2'b00;
                if (vblnk && sel_valid) begin
                    grant_next = sel_idx ? 2'b10 : 2'b01;
                    tcnt_next  = '0;
                end
            end
            ST_GRANT: begin
                // The counter holds at its last value instead of wrapping.
                tcnt_next = timeout_hit ? tcnt : tcnt + TW'(1);
                if (done_hit) begin
                    grant_next         = 2'b00;
                    served_next[g_idx] = 1'b1;
                    rr_next            = ~g_idx;
                end else if (fall) begin
                    grant_next = 2'b00;
                    abort_next = 1'b1;
                end else if (timeout_hit) begin
                    grant_next         = 2'b00;
                    abort_next         = 1'b1;
                    served_next[g_idx] = 1'b1;
                    rr_next            = ~g_idx;
                end
            end
            default: begin
                grant_next = 2'b00;
            end
        endcase
    end

    // Register the outputs and bookkeeping; reset revokes any grant at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d    <= 1'b0;
            frame_tick <= 1'b0;
            grant      <= 2'b00;
            abort      <= 1'b0;
            busy       <= 1'b0;
            served     <= 2'b00;
            rr_ptr     <= 1'b0;
            tcnt       <= '0;
        end else begin
            vblnk_d    <= vblnk;
            frame_tick <= rise;
            grant      <= grant_next;
            abort      <= abort_next;
            busy       <= |grant_next;
            served     <= served_next;
            rr_ptr     <= rr_next;
            tcnt       <= tcnt_next;
        end
    end

`ifdef FRAME_COUNTER_EN
    // Count blanking intervals; this advances on the same edge as frame_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (rise) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vblank_arbiter.sv
// tb_vblank_arbiter: self-checking bench for vblank_arbiter.
// The bench pushes each expected grant into exp_q when it drives the
// stimulus. A negedge monitor pops and compares the queue whenever a new
// grant appears. Each scenario task makes its own inline checks. The
// frame counter is expected to be active only with FRAME_COUNTER_EN.

module tb_vblank_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        vblnk = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic [1:0]  done  = 2'b00;
    logic [1:0]  grant;
    logic        frame_tick;
    logic        abort;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [1:0]  fsm_state;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          rises      = 0;
    int          abort_seen = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;
    logic [1:0]  prev_grant = 2'b00;

    vblank_arbiter #(.TIMEOUT(TIMEOUT), .TW(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .frame_tick (frame_tick),
        .abort      (abort),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .fsm_state  (fsm_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Scoreboard monitor: each new nonzero grant must match the next expected entry.
    always @(negedge clk) begin
        if (grant !== prev_grant && grant !== 2'b00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_order: got grant %b, expected no grant", grant);
            end else begin
                mon_exp = exp_q.pop_front();
                if (grant !== mon_exp) begin
                    n_fail++;
                    $display("FAIL grant_order: got grant %b, expected %b", grant, mon_exp);
                end
            end
        end
        n_checks++;
        if (grant === 2'b11) begin
            n_fail++;
            $display("FAIL grant_onehot: got grant %b, expected at most one bit", grant);
        end
        if (abort === 1'b1) abort_seen++;
        prev_grant = grant;
    end

    function automatic logic [15:0] exp_fc();
`ifdef FRAME_COUNTER_EN
        return 16'(rises);
`else
        return 16'd0;
`endif
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        vblnk = 1'b1;
        rises++;
    endtask

    task automatic end_frame();
        vblnk = 1'b0;
        step(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; vblnk = 1'b0; req = 2'b00; done = 2'b00;
        step(3);
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_grant: got grant=%b busy=%b, expected 00/0", grant, busy);
        end
        n_checks++;
        if (frame_tick !== 1'b0 || abort !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got tick=%b abort=%b, expected 0/0", frame_tick, abort);
        end
        n_checks++;
        if (frame_cnt !== 16'd0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d state=%0d, expected 0/0", frame_cnt, fsm_state);
        end
        rst = 1'b0;
        rises = 0;
        step(1);
    endtask

    task automatic test_idle();
        req = 2'b11;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            n_checks++;
            if (grant !== 2'b00 || frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got grant=%b tick=%b, expected 00/0", i, grant, frame_tick);
            end
        end
    endtask

    task automatic test_round_robin();
        req = 2'b11;
        exp_q.push_back(2'b01);
        start_frame();
        step(1);
        n_checks++;
        if (frame_tick !== 1'b1 || grant !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_tick: got tick=%b grant=%b, expected 1/00", frame_tick, grant);
        end
        step(1);
        n_checks++;
        if (grant !== 2'b01 || frame_tick !== 1'b0 || busy !== 1'b1 || fsm_state !== 2'd2) begin
            n_fail++;
            $display("FAIL rr_first: got grant=%b tick=%b busy=%b state=%0d, expected 01/0/1/2",
                     grant, frame_tick, busy, fsm_state);
        end
        // A done pulse from the requester that does not hold the grant has no effect.
        done = 2'b10;
        step(1);
        done = 2'b00;
        step(3);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_foreign_done: got grant %b, expected 01", grant);
        end
        // Dropping req does not end the grant.
        req = 2'b00;
        step(3);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_req_drop: got grant %b, expected 01", grant);
        end
        req = 2'b11;
        exp_q.push_back(2'b10);
        done = 2'b01;
        step(1);
        done = 2'b00;
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_drop0: got grant %b, expected 00", grant);
        end
        step(1);
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_second: got grant %b, expected 10", grant);
        end
        done = 2'b10;
        step(1);
        done = 2'b00;
        step(20);
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || fsm_state !== 2'd1) begin
            n_fail++;
            $display("FAIL rr_no_third: got grant=%b busy=%b state=%0d, expected 00/0/1",
                     grant, busy, fsm_state);
        end
        end_frame();
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_back_active: got state %0d, expected 0", fsm_state);
        end
    endtask

    task automatic test_rr_toggle();
        // A single grant to requester 0 moves the round-robin pointer to 1.
        req = 2'b01;
        exp_q.push_back(2'b01);
        start_frame();
        step(2);
        done = 2'b01;
        step(1);
        done = 2'b00;
        step(5);
        end_frame();
        req = 2'b11;
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        start_frame();
        step(2);
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++;
            $display("FAIL toggle_first: got grant %b, expected 10", grant);
        end
        done = 2'b10;
        step(1);
        done = 2'b00;
        step(1);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL toggle_second: got grant %b, expected 01", grant);
        end
        done = 2'b01;
        step(1);
        done = 2'b00;
        step(3);
        end_frame();
    endtask

    task automatic test_timeout();
        int hi_cycles;
        int a0;
        hi_cycles = 0;
        a0 = abort_seen;
        req = 2'b01;
        exp_q.push_back(2'b01);
        start_frame();
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (grant[0] === 1'b1) hi_cycles++;
        end
        n_checks++;
        if (hi_cycles != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d grant cycles, expected %0d", hi_cycles, TIMEOUT);
        end
        n_checks++;
        if (abort_seen - a0 != 1) begin
            n_fail++;
            $display("FAIL timeout_abort: got %0d abort pulses, expected 1", abort_seen - a0);
        end
        end_frame();
    endtask

    task automatic test_done_fall();
        int a0;
        req = 2'b11;
        exp_q.push_back(2'b10);
        start_frame();
        step(2);
        a0 = abort_seen;
        vblnk = 1'b0;
        done = 2'b10;
        step(1);
        done = 2'b00;
        n_checks++;
        if (grant !== 2'b00 || abort !== 1'b0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL donefall_drop: got grant=%b abort=%b state=%0d, expected 00/0/0",
                     grant, abort, fsm_state);
        end
        step(3);
        n_checks++;
        if (abort_seen != a0) begin
            n_fail++;
            $display("FAIL donefall_abort: got %0d abort pulses, expected 0", abort_seen - a0);
        end
        exp_q.push_back(2'b01);
        start_frame();
        step(2);
        vblnk = 1'b0;
        step(1);
        n_checks++;
        if (grant !== 2'b00 || abort !== 1'b1 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL fall_abort: got grant=%b abort=%b state=%0d, expected 00/1/0",
                     grant, abort, fsm_state);
        end
        step(1);
        n_checks++;
        if (abort !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_abort_width: got abort %b, expected 0", abort);
        end
        step(3);
    endtask

    task automatic test_frame_cnt();
        req = 2'b00;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        rises = 0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            start_frame();
            step(1);
            n_checks++;
            if (frame_tick !== 1'b1 || frame_cnt !== exp_fc()) begin
                n_fail++;
                $display("FAIL frame_cnt%0d: got tick=%b cnt=%0d, expected 1/%0d",
                         i, frame_tick, frame_cnt, exp_fc());
            end
            step(1);
            end_frame();
        end
        n_checks++;
        if (frame_cnt !== exp_fc()) begin
            n_fail++;
            $display("FAIL frame_cnt_final: got %0d, expected %0d", frame_cnt, exp_fc());
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 2'b01;
        exp_q.push_back(2'b01);
        start_frame();
        step(2);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: got grant=%b busy=%b cnt=%0d, expected 00/0/0",
                     grant, busy, frame_cnt);
        end
        vblnk = 1'b0;
        rises = 0;
        step(2);
        rst = 1'b0;
        step(20);
        n_checks++;
        if (grant !== 2'b00 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_wait: got grant=%b state=%0d, expected 00/0", grant, fsm_state);
        end
        exp_q.push_back(2'b01);
        start_frame();
        step(2);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_regrant: got grant %b, expected 01", grant);
        end
        done = 2'b01;
        step(1);
        done = 2'b00;
        end_frame();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_round_robin();
        test_rr_toggle();
        test_timeout();
        test_done_fall();
        test_frame_cnt();
        test_reset_mid_grant();
        step(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d grants still expected, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
